// File: rtl/light_conflict_monitor_if.sv
// light_conflict_monitor_if: sequencer light codes in, lamp drive and fault status out
interface light_conflict_monitor_if;
  logic [2:0] n_lights, s_lights, e_lights, w_lights;
  logic       clr_fault;
  logic [2:0] n_lamp, s_lamp, e_lamp, w_lamp;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] fault_count;
  modport master (
    output n_lights, s_lights, e_lights, w_lights, clr_fault,
    input  n_lamp, s_lamp, e_lamp, w_lamp, fault, fault_code, fault_count
  );
  modport slave (
    input  n_lights, s_lights, e_lights, w_lights, clr_fault,
    output n_lamp, s_lamp, e_lamp, w_lamp, fault, fault_code, fault_count
  );
endinterface

// File: rtl/light_conflict_monitor.sv
// light_conflict_monitor: forwards legal light combinations, traps persistent
// illegal ones into flashing amber until operator clear plus clean recovery window.
module light_conflict_monitor #(
  parameter int FAULT_CYCLES   = 2,
  parameter int BLINK_HALF     = 4,
  parameter int RECOVER_CYCLES = 16
) (
  input logic clk,
  input logic rst_a_n,
  light_conflict_monitor_if.slave bus
);
  typedef enum logic [1:0] {NORMAL, PENDING, FLASH, RECOVER} state_t;
  localparam logic [2:0] RED = 3'b100, AMBER = 3'b010;
  state_t state;
  logic [3:0] trip_cnt;
  logic [7:0] win_cnt;
  logic phase, fault, bad_code, conflict, illegal;
  logic [11:0] lamps, lights;
  logic [1:0] fault_code, trip_type;
  logic [7:0] fault_count;
  function automatic logic valid(input logic [2:0] c);
    return c == 3'b100 || c == 3'b010 || c == 3'b001;
  endfunction
  always_comb begin
    lights = {bus.n_lights, bus.s_lights, bus.e_lights, bus.w_lights};
    bad_code = !(valid(bus.n_lights) && valid(bus.s_lights) && valid(bus.e_lights) && valid(bus.w_lights));
    conflict = $countones({bus.n_lights != RED, bus.s_lights != RED, bus.e_lights != RED, bus.w_lights != RED}) > 1;
    illegal = bad_code || conflict;
    trip_type = bad_code ? 2'b01 : 2'b10;
  end
  // win_cnt doubles as blink counter in FLASH and recovery window in RECOVER
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state <= NORMAL;
      lamps <= {4{RED}};
      fault <= 1'b0;
      fault_code <= 2'b00;
      fault_count <= 8'd0;
      trip_cnt <= 4'd0;
      win_cnt <= 8'd0;
      phase <= 1'b1;
    end else begin
      case (state)
        NORMAL:
          if (illegal) begin
            state <= PENDING;
            trip_cnt <= 4'd1;
          end else lamps <= lights;
        PENDING:
          if (!illegal) begin
            state <= NORMAL;
            trip_cnt <= 4'd0;
            lamps <= lights;
          end else if (trip_cnt == 4'(FAULT_CYCLES - 1)) begin
            state <= FLASH;
            trip_cnt <= 4'd0;
            lamps <= {4{AMBER}};
            phase <= 1'b1;
            win_cnt <= 8'd0;
            fault <= 1'b1;
            fault_code <= trip_type;
            if (fault_count != 8'hff) fault_count <= fault_count + 8'd1;
          end else trip_cnt <= trip_cnt + 4'd1;
        FLASH:
          if (bus.clr_fault) begin
            state <= RECOVER;
            lamps <= {4{RED}};
            win_cnt <= 8'd0;
          end else if (win_cnt == 8'(BLINK_HALF - 1)) begin
            win_cnt <= 8'd0;
            phase <= !phase;
            lamps <= phase ? 12'h000 : {4{AMBER}};
          end else begin
            win_cnt <= win_cnt + 8'd1;
            lamps <= phase ? {4{AMBER}} : 12'h000;
          end
        RECOVER:
          if (illegal) win_cnt <= 8'd0;
          else if (win_cnt == 8'(RECOVER_CYCLES - 1)) begin
            state <= NORMAL;
            win_cnt <= 8'd0;
            lamps <= lights;
            fault <= 1'b0;
          end else win_cnt <= win_cnt + 8'd1;
        default: state <= NORMAL;
      endcase
    end
  end
  assign {bus.n_lamp, bus.s_lamp, bus.e_lamp, bus.w_lamp} = lamps;
  assign bus.fault = fault;
  assign bus.fault_code = fault_code;
  assign bus.fault_count = fault_count;
endmodule

// File: tb/tb_light_conflict_monitor.sv
// tb_light_conflict_monitor: directed vectors with hand-computed lamp and fault expectations
module tb_light_conflict_monitor;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, X = 3'b011;
  localparam logic [11:0] ALL_R = {R, R, R, R}, ALL_Y = {Y, Y, Y, Y}, DARK = 12'h000;
  logic clk = 1'b0;
  logic rst_a_n = 1'b1;
  int n_cmp = 0, n_bad = 0;
  light_conflict_monitor_if bus ();
  light_conflict_monitor dut (.clk(clk), .rst_a_n(rst_a_n), .bus(bus));
  always #5 clk = !clk;
  wire [11:0] lamps = {bus.n_lamp, bus.s_lamp, bus.e_lamp, bus.w_lamp};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [11:0] v, input logic c);
    {bus.n_lights, bus.s_lights, bus.e_lights, bus.w_lights} = v;
    bus.clr_fault = c;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic trip_and_recover();
    drive({X, R, R, R}, 1'b0);
    tick();
    tick();
    drive({G, R, R, R}, 1'b1);
    tick();
    drive({G, R, R, R}, 1'b0);
    repeat (16) tick();
  endtask
  initial begin
    drive(ALL_R, 1'b0);
    #2 rst_a_n = 1'b0;
    #1;
    chk("rst_lamps", 32'(lamps), 32'(ALL_R));
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_code", 32'(bus.fault_code), 0);
    chk("rst_count", 32'(bus.fault_count), 0);
    @(negedge clk) rst_a_n = 1'b1;
    drive({G, R, R, R}, 1'b0); tick(); chk("pass_ng", 32'(lamps), 32'({G, R, R, R}));
    drive({Y, R, R, R}, 1'b0); tick(); chk("pass_ny", 32'(lamps), 32'({Y, R, R, R}));
    drive({R, G, R, R}, 1'b0); tick(); chk("pass_sg", 32'(lamps), 32'({R, G, R, R}));
    chk("pass_fault", 32'(bus.fault), 0);
    drive({G, R, G, R}, 1'b0); tick(); chk("glitch_hold", 32'(lamps), 32'({R, G, R, R}));
    chk("glitch_fault", 32'(bus.fault), 0);
    drive({G, R, R, R}, 1'b0); tick(); chk("glitch_resume", 32'(lamps), 32'({G, R, R, R}));
    chk("glitch_count", 32'(bus.fault_count), 0);
    drive({X, R, R, R}, 1'b0); tick(); chk("code_hold", 32'(lamps), 32'({G, R, R, R}));
    chk("code_pend_fault", 32'(bus.fault), 0);
    tick();
    chk("code_amber", 32'(lamps), 32'(ALL_Y));
    chk("code_fault", 32'(bus.fault), 1);
    chk("code_type", 32'(bus.fault_code), 32'h1);
    chk("code_count", 32'(bus.fault_count), 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("blink_%0d", i), 32'(lamps), 32'(((i / 4) % 2 == 0) ? ALL_Y : DARK));
    end
    drive({G, R, R, R}, 1'b1); tick();
    chk("clr_red", 32'(lamps), 32'(ALL_R));
    chk("clr_fault_held", 32'(bus.fault), 1);
    drive({G, R, R, R}, 1'b0);
    repeat (15) tick();
    chk("rec15_red", 32'(lamps), 32'(ALL_R));
    chk("rec15_fault", 32'(bus.fault), 1);
    tick();
    chk("rec16_pass", 32'(lamps), 32'({G, R, R, R}));
    chk("rec16_fault", 32'(bus.fault), 0);
    drive({R, G, R, R}, 1'b1); tick();
    chk("clr_ignored", 32'(lamps), 32'({R, G, R, R}));
    drive({R, G, R, Y}, 1'b0); tick(); chk("conf_hold", 32'(lamps), 32'({R, G, R, R}));
    tick();
    chk("conf_amber", 32'(lamps), 32'(ALL_Y));
    chk("conf_type", 32'(bus.fault_code), 32'h2);
    chk("conf_count", 32'(bus.fault_count), 2);
    drive({R, R, G, R}, 1'b1); tick();
    chk("conf_clr_red", 32'(lamps), 32'(ALL_R));
    drive({R, R, G, R}, 1'b0);
    repeat (9) tick();
    drive({G, G, R, R}, 1'b0); tick();
    drive({R, R, G, R}, 1'b0);
    repeat (15) tick();
    chk("restart_red", 32'(lamps), 32'(ALL_R));
    chk("restart_fault", 32'(bus.fault), 1);
    tick();
    chk("restart_pass", 32'(lamps), 32'({R, R, G, R}));
    chk("restart_fault_clr", 32'(bus.fault), 0);
    chk("code_sticky", 32'(bus.fault_code), 32'h2);
    drive({X, R, R, R}, 1'b0); tick(); tick();
    repeat (5) tick();
    chk("pre_rst_dark", 32'(lamps), 32'(DARK));
    #2 rst_a_n = 1'b0;
    #1;
    chk("arst_lamps", 32'(lamps), 32'(ALL_R));
    chk("arst_fault", 32'(bus.fault), 0);
    chk("arst_count", 32'(bus.fault_count), 0);
    chk("arst_code", 32'(bus.fault_code), 0);
    @(negedge clk) rst_a_n = 1'b1;
    drive({R, R, R, G}, 1'b0); tick();
    chk("arst_pass", 32'(lamps), 32'({R, R, R, G}));
    repeat (255) trip_and_recover();
    chk("sat_255", 32'(bus.fault_count), 255);
    trip_and_recover();
    chk("sat_hold", 32'(bus.fault_count), 255);
    chk("sat_fault", 32'(bus.fault), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
